// File: rtl/morse_keyer_if.sv
// Character-code handshake between a code source and the Morse keyer.
interface morse_keyer_if;
  logic [7:0] chr_data;
  logic       chr_valid;
  logic       chr_ready;

  modport master (output chr_data, output chr_valid, input chr_ready);
  modport slave  (input chr_data, input chr_valid, output chr_ready);
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: queues character codes in a FIFO and keys dits, dahs and
// inter-element / inter-character / word spaces timed in units of unit_len cycles.
module morse_keyer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 unit_len,
  input  logic                        abort,
  morse_keyer_if.slave                chr,
  output logic                        key,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, MARK, SPACE} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ready_en, push, pop;

  state_t        state, state_next;
  logic [7:0]    work;
  logic [2:0]    len, idx;
  logic          last;
  logic [25:0]   cnt, cnt_val, unit;
  logic          cnt_load, cnt_done, key_next;

  // Interval length in cycles minus one, so the counter expires at zero.
  function automatic logic [25:0] span(input logic [25:0] u, input logic [2:0] units);
    case (units)
      3'd3:    span = (u << 1) + u - 26'd1;
      3'd4:    span = (u << 2) - 26'd1;
      default: span = u - 26'd1;
    endcase
  endfunction

  assign unit          = (unit_len == 24'd0) ? 26'd1 : {2'b00, unit_len};
  assign len           = work[7:5];
  assign cnt_done      = (cnt == 26'd0);
  assign chr.chr_ready = ready_en && (level < DEPTH) && !abort;
  assign push          = chr.chr_valid && chr.chr_ready;
  assign fifo_level    = level;
  assign busy          = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= chr.chr_data;
    if (pop)  work <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (level != '0) state_next = LOAD;
        LOAD:    if (len > 3'd5)       state_next = IDLE;
                 else if (len == 3'd0) state_next = SPACE;
                 else                  state_next = MARK;
        MARK:    if (cnt_done) state_next = SPACE;
        SPACE:   if (cnt_done) state_next = last ? IDLE : MARK;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pop      = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    key_next = 1'b0;
    case (state)
      IDLE: pop = (level != '0) && !abort;
      LOAD: if (len <= 3'd5) begin
        cnt_load = 1'b1;
        if (len == 3'd0) cnt_val = span(unit, 3'd4);
        else             cnt_val = span(unit, work[0] ? 3'd3 : 3'd1);
      end
      MARK: begin
        key_next = 1'b1;
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = span(unit, (idx == len - 3'd1) ? 3'd3 : 3'd1);
        end
      end
      SPACE: if (cnt_done && !last) begin
        cnt_load = 1'b1;
        cnt_val  = span(unit, work[idx + 3'd1] ? 3'd3 : 3'd1);
      end
      default: ;
    endcase
  end

  // key is re-timed from the MARK state so it is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      last <= 1'b0;
      key  <= 1'b0;
    end else begin
      key <= key_next && !abort;
      if (abort) begin
        cnt  <= '0;
        idx  <= '0;
        last <= 1'b0;
      end else begin
        if (cnt_load)      cnt <= cnt_val;
        else if (!cnt_done) cnt <= cnt - 26'd1;
        case (state)
          LOAD:    begin
            idx  <= '0;
            last <= (len == 3'd0);
          end
          MARK:    if (cnt_done) last <= (idx == len - 3'd1);
          SPACE:   if (cnt_done && !last) idx <= idx + 3'd1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, power of two, number of queued character codes.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 unit_len  in  24  dit unit length in clk cycles; 0 treated as 1.
REQ-005 chr_data  in  8  character code: [7:5] element count L, [4:0] pattern, element i at bit i (LSB first), 1=dah, 0=dit.
REQ-006 chr_valid  in  1  chr_data valid.
REQ-007 chr_ready  out  1  FIFO can accept; a code transfers on a cycle with chr_valid & chr_ready.
REQ-008 abort  in  1  synchronous flush request.
REQ-009 key  out  1  registered transmitter key, drives radio enable; 1 = carrier on.
REQ-010 busy  out  1  1 when FIFO non-empty or FSM not in IDLE.
REQ-011 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued codes.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, MARK, SPACE.
REQ-013 IDLE SHALL go to LOAD on any edge where the FIFO is non-empty, popping one code into a working register.
REQ-014 LOAD SHALL decode the working code: L=0 means word space, SPACE for 4 units, then IDLE; L=1..5 means MARK for element 0; L=6..7 means discard, IDLE, no key activity.
REQ-015 MARK SHALL hold key=1 for exactly 1 unit (dit) or 3 units (dah), 1 unit = max(unit_len,1) cycles.
REQ-016 After a non-final element, SPACE SHALL hold key=0 for 1 unit, then MARK for the next element.
REQ-017 After the final element (index L-1), SPACE SHALL hold key=0 for 3 units, then IDLE.
REQ-018 unit_len SHALL be sampled on entry to each MARK/SPACE interval; mid-interval changes apply from the next interval only.
REQ-019 Latency: with FSM IDLE and FIFO empty, a code accepted on edge T SHALL give key=1 from edge T+3 (T+1 pop, T+2 LOAD, T+3 MARK).
REQ-020 The interval counter SHALL be at least 26 bits so 3*unit_len never wraps.
REQ-021 chr_ready SHALL be 1 when fifo_level < FIFO_DEPTH and abort=0.
REQ-022 A push and a pop on the same edge SHALL leave fifo_level unchanged and the data in order.
REQ-023 Total in flight SHALL be FIFO_DEPTH queued + 1 in the working register.
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH without loss.
REQ-025 abort=1 on an edge SHALL force key=0, fifo_level=0, FSM=IDLE on that edge; a simultaneous chr_valid is dropped.
REQ-026 busy SHALL fall on the edge the FSM returns to IDLE with the FIFO empty.
REQ-027 key SHALL come directly from a flop, glitch-free.

Reset
REQ-028 While rst=1: key=0, busy=0, fifo_level=0, chr_ready=0, FSM=IDLE, counters cleared, FIFO pointers 0.
REQ-029 After rst falls, chr_ready SHALL be 1 on the first edge.
REQ-030 Reset during MARK SHALL drop key asynchronously, with no partial element resumed after release.

Verification
REQ-031 unit_len=4, push 0x20 ('E', L=1 dit) into idle -> key=1 for 4 cycles from T+3, key=0 for 12 cycles, then busy=0.
REQ-032 unit_len=4, push 0x42 ('A', dit,dah) -> key 1/0/1/0 for 4/4/12/12 cycles; then push 0x00 -> a further 16 cycles of key=0.
REQ-033 unit_len=1000, push 12 codes back-to-back -> 9 accepted, chr_ready=0 with fifo_level=8, codes keyed in push order.
REQ-034 unit_len=10, abort 5 cycles into a dah -> key=0 and fifo_level=0 on the next edge, busy=0, next push keys normally.
REQ-035 unit_len=0 with push 0x20 -> key=1 for 1 cycle, then 0 for 3 cycles; push 0xE0 (L=7) -> no key activity, busy=0 within 3 cycles.
REQ-036 rst asserted mid-MARK -> key=0 immediately without waiting for clk; after release, all outputs are at reset values and the FIFO is empty.
